// File: rtl/btn_conditioner_single.sv
// Unused alias package; the per-button lane lives in btn_debounce_single.sv.
package btn_conditioner_single_unused_pkg;
    localparam int UNUSED = 0;
endpackage

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Defaults assume a 50 MHz mclk.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int MCLK_HZ                = 50_000_000;
    localparam int DEFAULT_DEBOUNCE       = MCLK_HZ / 1000;      // 1 ms
    localparam int DEFAULT_REPEAT_DELAY   = MCLK_HZ / 2;         // 0.5 s
    localparam int DEFAULT_REPEAT_PERIOD  = MCLK_HZ / 10;        // 0.1 s

endpackage

// File: rtl/btn_debounce_single.sv
// One button lane: 2-FF synchronizer, debounce FSM and auto-repeat timer.
// All outputs come straight from flops.
module btn_debounce_single
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX) + 1;
    localparam int RXW  = RCW + 1;

    localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RXW-1:0] RD_X     = RXW'(REPEAT_DELAY);
    localparam logic [RXW-1:0] RP_X     = RXW'(REPEAT_PERIOD);
    localparam bit             REP_ENAB = (REPEAT_DELAY != 0);

    logic           sync_meta_reg;
    logic           sync_reg;
    btn_state_t     state_reg;
    logic [DCW-1:0] db_cnt_reg;
    logic [RCW-1:0] rep_cnt_reg;
    logic           rep_first_reg;
    logic           level_reg;
    logic           press_reg;
    logic           release_reg;
    logic           repeat_reg;

    logic [DCW-1:0] db_cnt_next;
    logic [RXW-1:0] rep_cnt_ext;
    logic [RCW-1:0] rep_cnt_next;
    logic [RXW-1:0] rep_target;
    logic           rep_due;

    // Saturating increments; the repeat compare is done one bit wider so the
    // target value itself is always representable.
    assign db_cnt_next  = (&db_cnt_reg) ? db_cnt_reg : db_cnt_reg + DCW'(1);
    assign rep_cnt_ext  = {1'b0, rep_cnt_reg} + RXW'(1);
    assign rep_cnt_next = (&rep_cnt_reg) ? rep_cnt_reg : rep_cnt_ext[RCW-1:0];
    assign rep_target   = rep_first_reg ? RD_X : RP_X;
    assign rep_due      = REP_ENAB && (rep_cnt_ext == rep_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
            state_reg     <= IDLE;
            db_cnt_reg    <= '0;
            rep_cnt_reg   <= '0;
            rep_first_reg <= 1'b0;
            level_reg     <= 1'b0;
            press_reg     <= 1'b0;
            release_reg   <= 1'b0;
            repeat_reg    <= 1'b0;
        end else begin
            sync_meta_reg <= btn_raw;
            sync_reg      <= sync_meta_reg;
            press_reg     <= 1'b0;
            release_reg   <= 1'b0;
            repeat_reg    <= 1'b0;

            // The repeat schedule keeps ticking through release bounces so a
            // recovered hold stays on the original cadence.
            if (state_reg == HELD || state_reg == RELEASE_WAIT) begin
                if (rep_due) begin
                    rep_cnt_reg   <= '0;
                    rep_first_reg <= 1'b0;
                end else begin
                    rep_cnt_reg   <= rep_cnt_next;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (sync_reg) begin
                        state_reg  <= PRESS_WAIT;
                        db_cnt_reg <= DCW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_reg) begin
                        state_reg  <= IDLE;
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg     <= HELD;
                        db_cnt_reg    <= '0;
                        press_reg     <= 1'b1;
                        level_reg     <= 1'b1;
                        rep_cnt_reg   <= '0;
                        rep_first_reg <= 1'b1;
                    end else begin
                        db_cnt_reg <= db_cnt_next;
                    end
                end
                HELD: begin
                    if (!sync_reg) begin
                        state_reg  <= RELEASE_WAIT;
                        db_cnt_reg <= DCW'(1);
                    end else begin
                        repeat_reg <= rep_due;
                    end
                end
                RELEASE_WAIT: begin
                    // Repeats falling due here are dropped, never deferred.
                    if (sync_reg) begin
                        state_reg  <= HELD;
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg   <= IDLE;
                        db_cnt_reg  <= '0;
                        release_reg <= 1'b1;
                        level_reg   <= 1'b0;
                    end else begin
                        db_cnt_reg <= db_cnt_next;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    db_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign btn_repeat  = repeat_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent synchronize/debounce/repeat lanes.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_debounce_single #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_lane (
                .clk         (mclk),
                .rst         (rst),
                .btn_raw     (btn_raw[gi]),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi]),
                .btn_repeat  (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random buttons, all
// compared cycle-by-cycle against a run-length/elapsed-time reference model.
module tb_btn_conditioner;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RP = 3;
    localparam int RD_A = 10;
    localparam int RD_B = 0;

    logic          mclk = 1'b0;
    logic          rst;
    logic [NB-1:0] raw;

    logic [NB-1:0] lvl_a, prs_a, rel_a, rep_a;
    logic [NB-1:0] lvl_b, prs_b, rel_b, rep_b;

    always #5 mclk = ~mclk;

    btn_conditioner #(.N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD_A), .REPEAT_PERIOD(RP)) dut_a (
        .mclk(mclk), .rst(rst), .btn_raw(raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rep_a)
    );

    btn_conditioner #(.N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD_B), .REPEAT_PERIOD(RP)) dut_b (
        .mclk(mclk), .rst(rst), .btn_raw(raw),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rep_b)
    );

    // Reference model: a change is accepted once the synchronized input has
    // disagreed with the level for DB consecutive samples; repeats fall on
    // elapsed = RD + m*RP after the press, only while cleanly held.
    logic [NB-1:0] m_s1[2], m_s[2], m_lvl[2], m_prs[2], m_rel[2], m_rep[2];
    int            m_run[2][NB];
    int            m_t[2][NB];
    int            m_rd[2];

    initial begin
        m_rd[0] = RD_A;
        m_rd[1] = RD_B;
    end

    always @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] <= '0; m_s[i] <= '0; m_lvl[i] <= '0;
                m_prs[i] <= '0; m_rel[i] <= '0; m_rep[i] <= '0;
                for (int b = 0; b < NB; b++) begin
                    m_run[i][b] <= 0;
                    m_t[i][b]   <= 0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] <= raw;
                m_s[i]  <= m_s1[i];
                for (int b = 0; b < NB; b++) begin
                    logic sn, lv;
                    int   pr, nr, el;
                    sn = m_s[i][b];
                    lv = m_lvl[i][b];
                    pr = m_run[i][b];
                    nr = (sn != lv) ? pr + 1 : 0;
                    m_prs[i][b] <= 1'b0;
                    m_rel[i][b] <= 1'b0;
                    m_rep[i][b] <= 1'b0;
                    if (nr == DB) begin
                        m_lvl[i][b] <= ~lv;
                        m_run[i][b] <= 0;
                        if (!lv) begin
                            m_prs[i][b] <= 1'b1;
                            m_t[i][b]   <= 0;
                        end else begin
                            m_rel[i][b] <= 1'b1;
                        end
                    end else begin
                        m_run[i][b] <= nr;
                        if (lv) m_t[i][b] <= m_t[i][b] + 1;
                        el = m_t[i][b] + 1;
                        if (lv && sn && pr == 0 && m_rd[i] != 0 &&
                            el >= m_rd[i] && ((el - m_rd[i]) % RP) == 0)
                            m_rep[i][b] <= 1'b1;
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_press[2][NB];
    int n_rel[2][NB];
    int n_rep[2][NB];
    int press_cyc[2][NB];
    int rep_q[NB][$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < NB; b++) begin
                n_press[i][b] = 0; n_rel[i][b] = 0; n_rep[i][b] = 0;
                press_cyc[i][b] = -1;
            end
        end
        for (int b = 0; b < NB; b++) rep_q[b].delete();
    endtask

    task automatic compare_all();
        check_eq("a_level",   32'(lvl_a), 32'(m_lvl[0]));
        check_eq("a_press",   32'(prs_a), 32'(m_prs[0]));
        check_eq("a_release", 32'(rel_a), 32'(m_rel[0]));
        check_eq("a_repeat",  32'(rep_a), 32'(m_rep[0]));
        check_eq("b_level",   32'(lvl_b), 32'(m_lvl[1]));
        check_eq("b_press",   32'(prs_b), 32'(m_prs[1]));
        check_eq("b_release", 32'(rel_b), 32'(m_rel[1]));
        check_eq("b_repeat",  32'(rep_b), 32'(m_rep[1]));
        for (int b = 0; b < NB; b++) begin
            if (prs_a[b]) begin n_press[0][b]++; press_cyc[0][b] = cyc; end
            if (prs_b[b]) begin n_press[1][b]++; press_cyc[1][b] = cyc; end
            if (rel_a[b]) n_rel[0][b]++;
            if (rel_b[b]) n_rel[1][b]++;
            if (rep_a[b]) begin n_rep[0][b]++; rep_q[b].push_back(cyc - press_cyc[0][b]); end
            if (rep_b[b]) n_rep[1][b]++;
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge mclk);
            cyc++;
            compare_all();
        end
    endtask

    initial begin
        int chg;
        bit ok;
        rst = 1'b1;
        raw = '0;
        clear_stats();
        tick(3);
        check_eq("reset_level", 32'(lvl_a | lvl_b), 32'h0);
        rst = 1'b0;
        tick(3);
        $display("reset released at cycle %0d", cyc);

        // 1: clean press with repeats
        clear_stats();
        raw[0] = 1'b1; chg = cyc;
        tick(30);
        raw[0] = 1'b0;
        tick(15);
        check_eq("s1_press_count", 32'(n_press[0][0]), 32'd1);
        check_eq("s1_press_edges", 32'(press_cyc[0][0] - chg - 1), 32'd5);
        check_eq("s1_repeat_count", 32'(n_rep[0][0]), 32'd6);
        ok = (rep_q[0].size() == 6);
        for (int r = 0; r < rep_q[0].size(); r++)
            if (rep_q[0][r] != 10 + 3 * r) ok = 1'b0;
        check_eq("s1_repeat_offsets", 32'(ok), 32'd1);
        check_eq("s1_release_count", 32'(n_rel[0][0]), 32'd1);
        check_eq("s1_level_after", 32'(lvl_a[0]), 32'd0);
        $display("scenario 1 clean press: press=%0d repeats=%0d release=%0d", n_press[0][0], n_rep[0][0], n_rel[0][0]);

        // 2: press-side bounce
        clear_stats();
        raw[1] = 1'b1; tick(1);
        raw[1] = 1'b0; tick(1);
        raw[1] = 1'b1; tick(2);
        raw[1] = 1'b0; tick(1);
        check_eq("s2_no_press_in_bounce", 32'(n_press[0][1]), 32'd0);
        raw[1] = 1'b1; chg = cyc;
        tick(12);
        check_eq("s2_press_count", 32'(n_press[0][1]), 32'd1);
        check_eq("s2_press_edges", 32'(press_cyc[0][1] - chg - 1), 32'd5);
        raw[1] = 1'b0;
        tick(10);
        $display("scenario 2 press bounce: press=%0d release=%0d", n_press[0][1], n_rel[0][1]);

        // 3: release-side bounce while held
        clear_stats();
        raw[2] = 1'b1;
        tick(20);
        raw[2] = 1'b0; tick(2);
        raw[2] = 1'b1; tick(20);
        check_eq("s3_no_release_in_bounce", 32'(n_rel[0][2]), 32'd0);
        check_eq("s3_level_held", 32'(lvl_a[2]), 32'd1);
        ok = (rep_q[2].size() >= 4);
        for (int r = 0; r < rep_q[2].size(); r++)
            if (rep_q[2][r] < 10 || ((rep_q[2][r] - 10) % 3) != 0) ok = 1'b0;
        check_eq("s3_repeat_cadence", 32'(ok), 32'd1);
        raw[2] = 1'b0;
        tick(10);
        check_eq("s3_release_count", 32'(n_rel[0][2]), 32'd1);
        $display("scenario 3 release bounce: repeats=%0d release=%0d", n_rep[0][2], n_rel[0][2]);

        // 4: simultaneous buttons
        clear_stats();
        raw[0] = 1'b1; raw[3] = 1'b1; chg = cyc;
        tick(8);
        check_eq("s4_press_same_cycle", 32'(press_cyc[0][3]), 32'(press_cyc[0][0]));
        check_eq("s4_press_edges", 32'(press_cyc[0][0] - chg - 1), 32'd5);
        check_eq("s4_idle_bits", 32'(n_press[0][1] + n_press[0][2]), 32'd0);
        raw = '0;
        tick(10);
        $display("scenario 4 simultaneous: press0=%0d press3=%0d", n_press[0][0], n_press[0][3]);

        // 5: reset mid-hold
        clear_stats();
        raw[0] = 1'b1;
        tick(12);
        #2 rst = 1'b1;
        #1;
        check_eq("s5_async_level",   32'({lvl_a, lvl_b}), 32'h0);
        check_eq("s5_async_strobes", 32'({prs_a, rel_a, rep_a, prs_b, rel_b, rep_b}), 32'h0);
        tick(2);
        rst = 1'b0; chg = cyc;
        tick(15);
        check_eq("s5_press_count", 32'(n_press[0][0]), 32'd2);
        check_eq("s5_press_edges", 32'(press_cyc[0][0] - chg - 1), 32'd5);
        check_eq("s5_no_release", 32'(n_rel[0][0]), 32'd0);
        raw[0] = 1'b0;
        tick(10);
        $display("scenario 5 reset mid-hold: presses=%0d", n_press[0][0]);

        // 6: repeat disabled (instance b)
        clear_stats();
        raw[1] = 1'b1;
        tick(50);
        raw[1] = 1'b0;
        tick(12);
        check_eq("s6_press_count", 32'(n_press[1][1]), 32'd1);
        check_eq("s6_release_count", 32'(n_rel[1][1]), 32'd1);
        check_eq("s6_no_repeat", 32'(n_rep[1][1]), 32'd0);
        $display("scenario 6 repeat disabled: press=%0d release=%0d repeats=%0d", n_press[1][1], n_rel[1][1], n_rep[1][1]);

        // random phase: sparse toggles give bounces, clean holds and repeats
        clear_stats();
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 11) == 0) raw[b] = ~raw[b];
            tick(1);
        end
        $display("random phase: presses=%0d repeats=%0d", n_press[0][0] + n_press[0][1] + n_press[0][2] + n_press[0][3],
                 n_rep[0][0] + n_rep[0][1] + n_rep[0][2] + n_rep[0][3]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
